frame_buffer: RTL and testbench



---
 rtl/types_pkg.sv | 20 ++
 rtl/frame_bank.sv | 23 ++
 rtl/frame_buffer.sv | 114 +++++++++++
 tb/tb_frame_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared pixel, colour and frame buffer state types
package types_pkg;

  localparam int COLOR_WIDTH = 12;
  localparam int DEPTH_WIDTH = 16;

  typedef logic [COLOR_WIDTH-1:0] color_t;

  typedef struct packed {
    color_t                 color;
    logic [DEPTH_WIDTH-1:0] depth;
  } pixel_data_t;

  typedef enum logic [1:0] {
    CLEAR,
    RENDER,
    WAIT_SWAP
  } fb_state_t;

endpackage

// File: rtl/frame_bank.sv
// rtl/frame_bank.sv - simple dual-port colour RAM, one write port and one registered read port
module frame_bank
  import types_pkg::*;
#(
  parameter int DEPTH      = 19200,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wen,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [COLOR_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [COLOR_WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [COLOR_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - double-buffered colour frame buffer with swap at vblank and clear sweep
module frame_buffer
  import types_pkg::*;
#(
  parameter int                     BUFFER_WIDTH      = 160,
  parameter int                     BUFFER_HEIGHT     = 120,
  parameter int                     BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR       = 12'h000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         write_en_in,
  input  logic [BUFFER_ADDR_WIDTH-1:0] write_addr_in,
  input  pixel_data_t                  write_pixel_in,
  input  logic                         frame_done_in,
  input  logic                         vblank_in,
  input  logic [BUFFER_ADDR_WIDTH-1:0] read_addr_in,
  output logic [COLOR_WIDTH-1:0]       read_data_out,
  output logic                         depth_clear_req_out,
  output logic [BUFFER_ADDR_WIDTH-1:0] depth_clear_addr_out,
  output logic                         render_ready_out,
  output logic                         front_sel_out,
  output logic                         swap_pulse_out
);

  localparam int N      = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam int RAM_AW = $clog2(N);
  localparam logic [BUFFER_ADDR_WIDTH:0]   N_EXT     = (BUFFER_ADDR_WIDTH+1)'(N);
  localparam logic [BUFFER_ADDR_WIDTH-1:0] LAST_ADDR = BUFFER_ADDR_WIDTH'(N-1);

  fb_state_t                    state;
  logic [BUFFER_ADDR_WIDTH-1:0] clr_cnt;
  logic                         front_sel;
  logic                         rd_valid_q;
  logic                         rd_sel_q;

  logic                         pix_ok;
  logic                         rd_ok;
  logic                         wr_en;
  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr;
  logic [COLOR_WIDTH-1:0]       wr_data;
  logic [1:0]                   bank_we;
  logic [COLOR_WIDTH-1:0]       rd_data [2];
  logic                         unused_depth;

  assign unused_depth = ^write_pixel_in.depth;

  // The clear sweep owns the back-bank write port; pixel writes only land outside CLEAR.
  assign pix_ok  = write_en_in && (state != CLEAR) && ({1'b0, write_addr_in} < N_EXT);
  assign rd_ok   = {1'b0, read_addr_in} < N_EXT;
  assign wr_en   = rstn && ((state == CLEAR) || pix_ok);
  assign wr_addr = (state == CLEAR) ? clr_cnt : write_addr_in;
  assign wr_data = (state == CLEAR) ? CLEAR_COLOR : write_pixel_in.color;

  assign bank_we[0] = wr_en & front_sel;
  assign bank_we[1] = wr_en & ~front_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .DEPTH      (N),
      .ADDR_WIDTH (RAM_AW)
    ) u_bank (
      .clk   (clk),
      .wen   (bank_we[b]),
      .waddr (wr_addr[RAM_AW-1:0]),
      .wdata (wr_data),
      .raddr (read_addr_in[RAM_AW-1:0]),
      .rdata (rd_data[b])
    );
  end

  assign read_data_out = rd_valid_q ? rd_data[rd_sel_q] : '0;
  assign front_sel_out = front_sel;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                <= CLEAR;
      clr_cnt              <= '0;
      front_sel            <= 1'b0;
      rd_valid_q           <= 1'b0;
      rd_sel_q             <= 1'b0;
      depth_clear_req_out  <= 1'b0;
      depth_clear_addr_out <= '0;
      render_ready_out     <= 1'b0;
      swap_pulse_out       <= 1'b0;
    end else begin
      rd_valid_q           <= rd_ok;
      rd_sel_q             <= front_sel;
      depth_clear_req_out  <= (state == CLEAR);
      depth_clear_addr_out <= (state == CLEAR) ? clr_cnt : '0;
      render_ready_out     <= (state == RENDER);
      swap_pulse_out       <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) state <= RENDER;
          else                      clr_cnt <= clr_cnt + 1'b1;
        end
        RENDER: begin
          if (frame_done_in) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (vblank_in) begin
            front_sel      <= ~front_sel;
            swap_pulse_out <= 1'b1;
            clr_cnt        <= '0;
            state          <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// tb/tb_frame_buffer.sv - randomized scoreboard bench for frame_buffer against a bank-level model
module tb_frame_buffer;
  import types_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 6;
  localparam color_t CLR = 12'h000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          write_en = 1'b0;
  logic [AW-1:0] write_addr = '0;
  pixel_data_t   write_pixel = '0;
  logic          frame_done = 1'b0;
  logic          vblank = 1'b0;
  logic [AW-1:0] read_addr = '0;
  color_t        read_data;
  logic          depth_req;
  logic [AW-1:0] depth_addr;
  logic          ready;
  logic          front_sel;
  logic          swap_pulse;

  frame_buffer #(
    .BUFFER_WIDTH      (W),
    .BUFFER_HEIGHT     (H),
    .BUFFER_ADDR_WIDTH (AW),
    .CLEAR_COLOR       (CLR)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .write_en_in          (write_en),
    .write_addr_in        (write_addr),
    .write_pixel_in       (write_pixel),
    .frame_done_in        (frame_done),
    .vblank_in            (vblank),
    .read_addr_in         (read_addr),
    .read_data_out        (read_data),
    .depth_clear_req_out  (depth_req),
    .depth_clear_addr_out (depth_addr),
    .render_ready_out     (ready),
    .front_sel_out        (front_sel),
    .swap_pulse_out       (swap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic   known;
    color_t val;
  } exp_t;

  int     checks = 0;
  int     failures = 0;
  color_t model [2][N];
  bit     known [2][N];
  int     fs = 0;
  bit     in_clear = 1'b1;
  logic   rd_req = 1'b0;
  exp_t   exp_q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a read for the next edge (expected value from the model's front bank) and advance one cycle.
  task automatic step_at(int a);
    exp_t e;
    if (rstn) begin
      read_addr = AW'(a);
      rd_req = 1'b1;
      if (a >= N) begin
        e.known = 1'b1;
        e.val = '0;
      end else begin
        e.known = known[fs][a];
        e.val = model[fs][a];
      end
      exp_q.push_back(e);
    end else begin
      rd_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic step();
    step_at(int'($urandom_range(0, N + 9)));
  endtask

  task automatic set_write(bit en, int a, color_t c);
    write_en = en;
    write_addr = AW'(a);
    write_pixel.color = c;
    write_pixel.depth = 16'($urandom);
    if (en && !in_clear && a < N) begin
      model[1-fs][a] = c;
      known[1-fs][a] = 1'b1;
    end
  endtask

  // Addresses 3, 5 and 7 carry directed values, so random traffic leaves them alone.
  task automatic rand_write();
    int a;
    bit en;
    a = int'($urandom_range(0, N + 9));
    en = bit'($urandom_range(0, 1));
    if (a == 3 || a == 5 || a == 7) en = 1'b0;
    set_write(en, a, color_t'($urandom));
  endtask

  task automatic sweep_check(bit inject, int first_read);
    for (int k = 0; k < N; k++) begin
      if (inject && k == 10) set_write(1'b1, 7, 12'h0F0);
      else set_write(1'b0, 0, '0);
      if (k == 0 && first_read >= 0) step_at(first_read);
      else step();
      chk("clear_req", depth_req, 1);
      chk("clear_addr", depth_addr, k);
      chk("ready_in_clear", ready, 0);
      chk("front_in_clear", front_sel, fs);
      if (k == 0) chk("swap_one_cycle", swap_pulse, 0);
    end
    for (int a = 0; a < N; a++) begin
      model[1-fs][a] = CLR;
      known[1-fs][a] = 1'b1;
    end
    in_clear = 1'b0;
    set_write(1'b0, 0, '0);
    step();
    chk("clear_req_off", depth_req, 0);
    chk("ready_after_clear", ready, 1);
  endtask

  task automatic end_frame(int gap);
    frame_done = 1'b1;
    rand_write();
    step();
    chk("ready_at_done", ready, 1);
    frame_done = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rand_write();
      step();
      chk("ready_wait", ready, 0);
      chk("swap_wait", swap_pulse, 0);
    end
  endtask

  task automatic do_swap(int ra);
    vblank = 1'b1;
    set_write(1'b0, 0, '0);
    if (ra >= 0) step_at(ra);
    else step();
    chk("swap_pulse", swap_pulse, 1);
    chk("front_after_swap", front_sel, 1 - fs);
    fs = 1 - fs;
    in_clear = 1'b1;
    vblank = 1'b0;
  endtask

  task automatic reset_outputs(string tag);
    chk({tag, "_read_data"}, read_data, 0);
    chk({tag, "_clear_req"}, depth_req, 0);
    chk({tag, "_clear_addr"}, depth_addr, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_front"}, front_sel, 0);
    chk({tag, "_swap"}, swap_pulse, 0);
  endtask

  initial begin : monitor
    logic pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = rd_req;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.known) chk("read_data", read_data, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    reset_outputs("reset");
    rstn = 1'b1;
    sweep_check(1'b1, -1);

    // Frame 1: directed writes, ignored vblank, then frame_done with vblank in the same cycle.
    set_write(1'b1, 5, 12'hF00);
    step();
    chk("ready_render", ready, 1);
    set_write(1'b1, 40, 12'hFFF);
    step();
    vblank = 1'b1;
    set_write(1'b0, 0, '0);
    step();
    chk("vblank_in_render", swap_pulse, 0);
    chk("front_in_render", front_sel, 0);
    vblank = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rand_write();
      step();
      chk("ready_render", ready, 1);
    end
    frame_done = 1'b1;
    vblank = 1'b1;
    set_write(1'b0, 0, '0);
    step();
    chk("ready_same_cycle", ready, 1);
    chk("swap_same_cycle", swap_pulse, 0);
    frame_done = 1'b0;
    vblank = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) set_write(1'b1, 3, 12'h00F);
      else rand_write();
      frame_done = (i == 70);
      step();
      chk("ready_wait_swap", ready, 0);
      chk("no_swap_without_vblank", swap_pulse, 0);
      chk("front_wait_swap", front_sel, 0);
    end
    frame_done = 1'b0;
    do_swap(-1);
    sweep_check(1'b0, 5);

    // Frame 2: read the whole new front bank, write a marker to addr 5 of the back bank.
    for (int a = 0; a <= N; a++) begin
      if (a == 9) set_write(1'b1, 5, 12'hABC);
      else rand_write();
      step_at(a == N ? 40 : a);
      chk("ready_render2", ready, 1);
    end
    end_frame(1);
    do_swap(5);
    sweep_check(1'b0, 5);

    // Frame 3: read back the frame-2 bank, then swap and reset in the middle of the sweep.
    for (int a = 0; a < N; a++) begin
      rand_write();
      step_at(a);
    end
    end_frame(3);
    do_swap(-1);
    for (int k = 0; k < 17; k++) begin
      set_write(1'b0, 0, '0);
      step();
      chk("partial_clear_addr", depth_addr, k);
      model[1-fs][k] = CLR;
      known[1-fs][k] = 1'b1;
    end
    rstn = 1'b0;
    step();
    reset_outputs("midsweep_reset");
    fs = 0;
    in_clear = 1'b1;
    rstn = 1'b1;
    sweep_check(1'b0, -1);
    for (int a = 0; a < N; a++) begin
      set_write(1'b0, 0, '0);
      step_at(a);
    end

    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
